// File: rtl/components_pkg.sv
// components_pkg: shared types, constants and helpers for the packet mux datapath.
//   mux_state_e   - packet arbiter state (IDLE / LOCKED)
//   PKT_CNT_WIDTH - width of the per-source packet counters
//   get_width(n)  - bits needed to index n items (minimum 1)
//   rr_select     - first set request at or after a rotating pointer
package components_pkg;

    typedef enum logic {IDLE, LOCKED} mux_state_e;

    localparam int PKT_CNT_WIDTH = 32;

    function automatic int get_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Walk from the highest rotated offset down so the lowest offset that
    // hits is the one left in sel; fixed 16-entry bound keeps it synthesizable.
    function automatic logic [3:0] rr_select(input logic [15:0] req, input logic [3:0] ptr, input int n);
        logic [3:0] sel;
        logic [3:0] idx;
        sel = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i < n) begin
                idx = 4'((int'(ptr) + i) % n);
                if (req[idx]) sel = idx;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/packet_rr_mux_if.sv
// packet_rr_mux_if: Avalon-ST bundle for the packet mux.
//   i_avst_* / o_avst_ready_in : NUM_PORTS source lanes (packed per port)
//   o_avst_* / i_avst_ready    : merged output stream with channel tag
//   modport master : source/sink side (drives inputs, downstream ready)
//   modport slave  : the mux itself
interface packet_rr_mux_if #(
    parameter int NUM_PORTS        = 4,
    parameter int AVST_DATA_WIDTH  = 64,
    parameter int AVST_ERROR_WIDTH = 1,
    parameter int USER_DATA_WIDTH  = 64,
    parameter int BIT_POSITION     = 0
);
    import components_pkg::*;

    localparam int AVST_CHANNEL_WIDTH = BIT_POSITION ? NUM_PORTS : get_width(NUM_PORTS);
    localparam int AVST_EMPTY_WIDTH   = get_width(AVST_DATA_WIDTH) - 3;

    logic [NUM_PORTS-1:0]                        i_avst_valid;
    logic [NUM_PORTS-1:0]                        o_avst_ready_in;
    logic [NUM_PORTS-1:0]                        i_avst_startofpacket;
    logic [NUM_PORTS-1:0]                        i_avst_endofpacket;
    logic [NUM_PORTS-1:0][AVST_DATA_WIDTH-1:0]   i_avst_data;
    logic [NUM_PORTS-1:0][AVST_EMPTY_WIDTH-1:0]  i_avst_empty;
    logic [NUM_PORTS-1:0][AVST_ERROR_WIDTH-1:0]  i_avst_error;
    logic [NUM_PORTS-1:0][USER_DATA_WIDTH-1:0]   i_avst_user_data;

    logic                          o_avst_valid;
    logic                          o_avst_startofpacket;
    logic                          o_avst_endofpacket;
    logic [AVST_DATA_WIDTH-1:0]    o_avst_data;
    logic [AVST_EMPTY_WIDTH-1:0]   o_avst_empty;
    logic [AVST_ERROR_WIDTH-1:0]   o_avst_error;
    logic [USER_DATA_WIDTH-1:0]    o_avst_user_data;
    logic [AVST_CHANNEL_WIDTH-1:0] o_avst_channel;
    logic                          i_avst_ready;

    modport master (
        output i_avst_valid, i_avst_startofpacket, i_avst_endofpacket,
        output i_avst_data, i_avst_empty, i_avst_error, i_avst_user_data,
        input  o_avst_ready_in,
        input  o_avst_valid, o_avst_startofpacket, o_avst_endofpacket,
        input  o_avst_data, o_avst_empty, o_avst_error, o_avst_user_data, o_avst_channel,
        output i_avst_ready
    );

    modport slave (
        input  i_avst_valid, i_avst_startofpacket, i_avst_endofpacket,
        input  i_avst_data, i_avst_empty, i_avst_error, i_avst_user_data,
        output o_avst_ready_in,
        output o_avst_valid, o_avst_startofpacket, o_avst_endofpacket,
        output o_avst_data, o_avst_empty, o_avst_error, o_avst_user_data, o_avst_channel,
        input  i_avst_ready
    );

endinterface

// File: rtl/avst_pipe_reg.sv
// avst_pipe_reg: single-stage valid/ready register for an opaque payload.
//   i_valid/o_ready/i_data : upstream side (o_ready = register empty or draining)
//   o_valid/i_ready/o_data : downstream side
//   clk, rst               : clock, synchronous active-high reset (clears valid)
module avst_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign o_ready = !valid_q || i_ready;

    always_comb begin
        valid_d = o_ready ? i_valid : valid_q;
        data_d  = (o_ready && i_valid) ? i_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // Payload needs no reset: it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/packet_rr_mux.sv
// packet_rr_mux: round-robin, packet-locked merge of NUM_PORTS Avalon-ST sources.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : per-source input lanes and merged, channel-tagged output
//   o_pkt_count  : per-source accepted-packet counters (only with PKT_MUX_STATS_EN)
// Optional macro: PKT_MUX_STATS_EN enables the packet counters.
module packet_rr_mux
    import components_pkg::*;
#(
    parameter int NUM_PORTS        = 4,
    parameter int AVST_DATA_WIDTH  = 64,
    parameter int AVST_ERROR_WIDTH = 1,
    parameter int USER_DATA_WIDTH  = 64,
    parameter int BIT_POSITION     = 0
) (
    input logic             clk,
    input logic             rst,
    packet_rr_mux_if.slave  bus
`ifdef PKT_MUX_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][PKT_CNT_WIDTH-1:0] o_pkt_count
`endif
);
    localparam int GW = get_width(NUM_PORTS);
    localparam int CW = BIT_POSITION ? NUM_PORTS : get_width(NUM_PORTS);
    localparam int MW = get_width(AVST_DATA_WIDTH) - 3;
    localparam int PW = 2 + AVST_DATA_WIDTH + MW + AVST_ERROR_WIDTH + USER_DATA_WIDTH + CW;

    mux_state_e           state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] sop_req;
    logic [NUM_PORTS-1:0] ready;
    logic                 load;
    logic                 pipe_valid;
    logic                 beat_acc;
    logic [CW-1:0]        chan;
    logic [PW-1:0]        payload;
    logic [PW-1:0]        out_payload;

    assign sop_req = bus.i_avst_valid & bus.i_avst_startofpacket;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        ready      = '0;
        pipe_valid = 1'b0;
        if (state_q == IDLE) begin
            // Orphan beats (valid without SOP) are swallowed so a broken source cannot stall the mux.
            ready = bus.i_avst_valid & ~bus.i_avst_startofpacket;
            if (|sop_req) begin
                grant_d = GW'(rr_select(16'(sop_req), 4'(rr_ptr_q), NUM_PORTS));
                state_d = LOCKED;
            end
        end else begin
            ready[grant_q] = load;
            pipe_valid     = bus.i_avst_valid[grant_q];
            if (pipe_valid && load && bus.i_avst_endofpacket[grant_q]) begin
                state_d  = IDLE;
                rr_ptr_d = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + GW'(1);
            end
        end
    end

    assign beat_acc            = (state_q == LOCKED) && pipe_valid && load;
    assign bus.o_avst_ready_in = rst ? '0 : ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    if (BIT_POSITION != 0) begin : g_onehot
        assign chan = CW'(1) << grant_q;
    end else begin : g_binary
        assign chan = CW'(grant_q);
    end

    assign payload = {bus.i_avst_startofpacket[grant_q], bus.i_avst_endofpacket[grant_q],
                      bus.i_avst_data[grant_q], bus.i_avst_empty[grant_q],
                      bus.i_avst_error[grant_q], bus.i_avst_user_data[grant_q], chan};

    avst_pipe_reg #(.WIDTH(PW)) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (pipe_valid),
        .o_ready (load),
        .i_data  (payload),
        .o_valid (bus.o_avst_valid),
        .i_ready (bus.i_avst_ready),
        .o_data  (out_payload)
    );

    assign {bus.o_avst_startofpacket, bus.o_avst_endofpacket, bus.o_avst_data, bus.o_avst_empty,
            bus.o_avst_error, bus.o_avst_user_data, bus.o_avst_channel} = out_payload;

`ifdef PKT_MUX_STATS_EN
    logic [NUM_PORTS-1:0][PKT_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (beat_acc && bus.i_avst_endofpacket[grant_q]) cnt_d[grant_q] = cnt_q[grant_q] + PKT_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign o_pkt_count = cnt_q;
`else
    logic unused_acc;
    assign unused_acc = beat_acc;
`endif

endmodule

// File: tb/tb_packet_rr_mux.sv
// tb_packet_rr_mux: self-checking bench for packet_rr_mux (binary and one-hot instances share stimulus).
module tb_packet_rr_mux;
    import components_pkg::*;

    localparam int NP = 4;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [63:0] data;
        logic [2:0]  empty;
        logic        err;
        logic [63:0] user;
        int          ch;
        int          ch1;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_rr_mux_if #(.NUM_PORTS(NP), .AVST_DATA_WIDTH(64), .AVST_ERROR_WIDTH(1),
                       .USER_DATA_WIDTH(64), .BIT_POSITION(0)) bus0 ();
    packet_rr_mux_if #(.NUM_PORTS(NP), .AVST_DATA_WIDTH(64), .AVST_ERROR_WIDTH(1),
                       .USER_DATA_WIDTH(64), .BIT_POSITION(1)) bus1 ();

    assign bus1.i_avst_valid         = bus0.i_avst_valid;
    assign bus1.i_avst_startofpacket = bus0.i_avst_startofpacket;
    assign bus1.i_avst_endofpacket   = bus0.i_avst_endofpacket;
    assign bus1.i_avst_data          = bus0.i_avst_data;
    assign bus1.i_avst_empty         = bus0.i_avst_empty;
    assign bus1.i_avst_error         = bus0.i_avst_error;
    assign bus1.i_avst_user_data     = bus0.i_avst_user_data;
    assign bus1.i_avst_ready         = bus0.i_avst_ready;

`ifdef PKT_MUX_STATS_EN
    logic [NP-1:0][31:0] cnt0, cnt1;
`endif

    packet_rr_mux #(.NUM_PORTS(NP), .AVST_DATA_WIDTH(64), .AVST_ERROR_WIDTH(1),
                    .USER_DATA_WIDTH(64), .BIT_POSITION(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
`ifdef PKT_MUX_STATS_EN
        , .o_pkt_count (cnt0)
`endif
    );

    packet_rr_mux #(.NUM_PORTS(NP), .AVST_DATA_WIDTH(64), .AVST_ERROR_WIDTH(1),
                    .USER_DATA_WIDTH(64), .BIT_POSITION(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
`ifdef PKT_MUX_STATS_EN
        , .o_pkt_count (cnt1)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    beat_t src_q[NP][$];
    beat_t exp_q[NP][$];
    beat_t out_log[$];

    int          rdy_mode;
    int          gap_pct;
    int          pat_idx;
    logic [NP-1:0] last_ready;
    logic [NP-1:0] last_valid;
    logic        last_load;
    logic        last_ovalid;
    bit          prev_stall;
    beat_t       prev_beat;
    bit          in_pkt;
    int          cur_ch;

    function automatic logic [133:0] pack(beat_t b);
        return {b.sop, b.eop, b.data, b.empty, b.err, b.user};
    endfunction

    function automatic beat_t rand_beat(int p, logic sop, logic eop);
        beat_t b;
        b.sop   = sop;
        b.eop   = eop;
        b.data  = {$urandom, $urandom};
        b.empty = eop ? 3'($urandom_range(7)) : 3'd0;
        b.err   = 1'($urandom_range(1));
        b.user  = {$urandom, $urandom};
        b.ch    = p;
        b.ch1   = 0;
        b.cyc   = 0;
        return b;
    endfunction

    task automatic push_pkt(int p, int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = rand_beat(p, 1'(i == 0), 1'(i == len - 1));
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    task automatic push_orphan(int p);
        src_q[p].push_back(rand_beat(p, 1'b0, 1'b0));
    endtask

    task automatic clear_inputs();
        bus0.i_avst_valid         = '0;
        bus0.i_avst_startofpacket = '0;
        bus0.i_avst_endofpacket   = '0;
        bus0.i_avst_data          = '0;
        bus0.i_avst_empty         = '0;
        bus0.i_avst_error         = '0;
        bus0.i_avst_user_data     = '0;
        bus0.i_avst_ready         = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        out_log.delete();
        prev_stall = 0;
        in_pkt     = 0;
        pat_idx    = 0;
        rdy_mode   = 0;
        gap_pct    = 0;
    endtask

    // One clock: present queue heads, sample at negedge+1, score the output beat, pop accepted inputs.
    task automatic run_cycle();
        beat_t         b;
        beat_t         e;
        logic [NP-1:0] acc;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && $urandom_range(99) >= gap_pct) begin
                b = src_q[p][0];
                bus0.i_avst_valid[p]         = 1'b1;
                bus0.i_avst_startofpacket[p] = b.sop;
                bus0.i_avst_endofpacket[p]   = b.eop;
                bus0.i_avst_data[p]          = b.data;
                bus0.i_avst_empty[p]         = b.empty;
                bus0.i_avst_error[p]         = b.err;
                bus0.i_avst_user_data[p]     = b.user;
            end else begin
                bus0.i_avst_valid[p] = 1'b0;
            end
        end
        bus0.i_avst_ready = (rdy_mode == 0) ? 1'b1 :
                            (rdy_mode == 1) ? 1'($urandom_range(99) < 70) :
                            1'((pat_idx % 4 == 0) || (pat_idx % 4 == 3));
        pat_idx++;
        #1;
        last_valid  = bus0.i_avst_valid;
        last_ready  = bus0.o_avst_ready_in;
        last_load   = !bus0.o_avst_valid || bus0.i_avst_ready;
        last_ovalid = bus0.o_avst_valid;
        acc         = last_valid & last_ready;
        b.sop   = bus0.o_avst_startofpacket;
        b.eop   = bus0.o_avst_endofpacket;
        b.data  = bus0.o_avst_data;
        b.empty = bus0.o_avst_empty;
        b.err   = bus0.o_avst_error;
        b.user  = bus0.o_avst_user_data;
        b.ch    = int'(bus0.o_avst_channel);
        b.ch1   = int'(bus1.o_avst_channel);
        b.cyc   = cyc;
        if (prev_stall) begin
            checks++;
            if (!bus0.o_avst_valid || pack(b) !== pack(prev_beat) || b.ch != prev_beat.ch) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d valid=%b ch=%0d data=%h, required held beat ch=%0d data=%h",
                         cyc, bus0.o_avst_valid, b.ch, b.data, prev_beat.ch, prev_beat.data);
            end
        end
        prev_stall = bus0.o_avst_valid && !bus0.i_avst_ready;
        prev_beat  = b;
        if (bus0.o_avst_valid && bus0.i_avst_ready) begin
            out_log.push_back(b);
            checks++;
            if (b.ch >= NP || exp_q[b.ch].size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected cyc=%0d got beat on ch=%0d, required no beat", cyc, b.ch);
            end else begin
                e = exp_q[b.ch].pop_front();
                if (pack(b) !== pack(e)) begin
                    errors++;
                    $display("FAIL sb_beat cyc=%0d ch=%0d got %h, required %h", cyc, b.ch, pack(b), pack(e));
                end
                checks++;
                if (b.ch1 != (1 << e.ch)) begin
                    errors++;
                    $display("FAIL sb_onehot cyc=%0d got %0h, required %0h", cyc, b.ch1, 1 << e.ch);
                end
            end
            checks++;
            if (in_pkt && b.ch != cur_ch) begin
                errors++;
                $display("FAIL sb_contiguous cyc=%0d got ch=%0d, required ch=%0d", cyc, b.ch, cur_ch);
            end
            if (!in_pkt) cur_ch = b.ch;
            in_pkt = !b.eop;
        end
        @(posedge clk);
        cyc++;
        for (int p = 0; p < NP; p++) if (acc[p]) void'(src_q[p].pop_front());
    endtask

    task automatic drain(int budget);
        int n;
        int pend;
        n = 0;
        do begin
            run_cycle();
            n++;
            pend = 0;
            for (int p = 0; p < NP; p++) pend += src_q[p].size() + exp_q[p].size();
        end while ((pend > 0 || last_ovalid) && n < budget);
        checks++;
        if (pend > 0 || last_ovalid) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d after %0d cycles, required 0", pend, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        bus0.i_avst_valid[1] = 1'b1;
        #1;
        checks++;
        if (bus0.o_avst_ready_in !== 4'b0000 || bus1.o_avst_ready_in !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got %b/%b, required 0000", bus0.o_avst_ready_in, bus1.o_avst_ready_in);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus0.o_avst_valid !== 1'b0 || bus1.o_avst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b/%b, required 0", bus0.o_avst_valid, bus1.o_avst_valid);
        end
        bus0.i_avst_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus0.o_avst_valid !== 1'b0 || bus0.o_avst_ready_in !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_idle got valid=%b ready=%b, required 0/0000",
                     bus0.o_avst_valid, bus0.o_avst_ready_in);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < NP; p++) push_pkt(p, 3);
        drain(200);
        checks++;
        if (out_log.size() != 12) begin
            errors++;
            $display("FAIL rr_count got %0d beats, required 12", out_log.size());
        end
        for (int i = 0; i < out_log.size() && i < 12; i++) begin
            checks++;
            if (out_log[i].ch != i / 3) begin
                errors++;
                $display("FAIL rr_order beat %0d got ch=%0d, required %0d", i, out_log[i].ch, i / 3);
            end
            if (i > 0) begin
                checks++;
                if (out_log[i].cyc - out_log[i-1].cyc != ((i % 3 == 0) ? 2 : 1)) begin
                    errors++;
                    $display("FAIL rr_spacing beat %0d got gap=%0d, required %0d", i,
                             out_log[i].cyc - out_log[i-1].cyc, (i % 3 == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int n0;
        int k0;
        int others;
        do_reset();
        for (int i = 0; i < 6; i++) push_pkt(2, 1);
        repeat (3) run_cycle();
        n0 = out_log.size();
        push_pkt(0, 2);
        drain(200);
        k0 = -1;
        for (int i = 0; i < out_log.size(); i++) if (k0 < 0 && out_log[i].ch == 0) k0 = i;
        checks++;
        if (k0 < 0) begin
            errors++;
            $display("FAIL fair_served got no port 0 beat, required one");
        end else begin
            others = 0;
            for (int i = n0; i < k0; i++) if (out_log[i].ch == 2) others++;
            checks++;
            if (others > 2) begin
                errors++;
                $display("FAIL fair_wait got %0d port2 packets before port0, required <=2", others);
            end
            checks++;
            if (k0 + 2 >= out_log.size() || out_log[k0+2].ch != 2) begin
                errors++;
                $display("FAIL fair_alternate got ch=%0d after port0 packet, required 2",
                         (k0 + 2 < out_log.size()) ? out_log[k0+2].ch : -1);
            end
        end
    endtask

    task automatic test_backpressure();
        bit mid;
        int n;
        do_reset();
        rdy_mode = 2;
        push_pkt(1, 5);
        n = 0;
        while (out_log.size() < 5 && n < 80) begin
            mid = src_q[1].size() > 0 && src_q[1].size() < 5;
            run_cycle();
            n++;
            if (mid) begin
                checks++;
                if (last_ready[1] !== last_load) begin
                    errors++;
                    $display("FAIL bp_ready_mirror cyc=%0d got %b, required %b", cyc, last_ready[1], last_load);
                end
            end
        end
        checks++;
        if (out_log.size() != 5) begin
            errors++;
            $display("FAIL bp_count got %0d beats, required 5", out_log.size());
        end
        for (int i = 0; i < out_log.size(); i++) begin
            checks++;
            if (out_log[i].ch != 1 || out_log[i].sop !== 1'(i == 0) || out_log[i].eop !== 1'(i == 4)) begin
                errors++;
                $display("FAIL bp_framing beat %0d got ch=%0d sop=%b eop=%b, required ch=1 sop=%b eop=%b",
                         i, out_log[i].ch, out_log[i].sop, out_log[i].eop, i == 0, i == 4);
            end
        end
        rdy_mode = 0;
        drain(50);
    endtask

    task automatic test_onehot();
        do_reset();
        push_pkt(3, 3);
        drain(50);
        checks++;
        if (out_log.size() != 3) begin
            errors++;
            $display("FAIL onehot_count got %0d beats, required 3", out_log.size());
        end
        for (int i = 0; i < out_log.size(); i++) begin
            checks++;
            if (out_log[i].ch1 != 8 || out_log[i].ch != 3) begin
                errors++;
                $display("FAIL onehot_chan beat %0d got %0h/%0d, required 8/3", i, out_log[i].ch1, out_log[i].ch);
            end
        end
    endtask

    task automatic test_orphan();
        do_reset();
        push_orphan(1);
        run_cycle();
        checks++;
        if (last_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL orphan_ready got %b, required 1", last_ready[1]);
        end
        repeat (3) run_cycle();
        checks++;
        if (out_log.size() != 0 || src_q[1].size() != 0) begin
            errors++;
            $display("FAIL orphan_discard got %0d out beats, %0d left, required 0/0", out_log.size(), src_q[1].size());
        end
        push_pkt(1, 2);
        drain(50);
        checks++;
        if (out_log.size() != 2 || out_log[0].ch != 1) begin
            errors++;
            $display("FAIL orphan_followup got %0d beats, required 2 on ch 1", out_log.size());
        end
        out_log.delete();
        push_pkt(0, 2);
        push_orphan(2);
        run_cycle();
        checks++;
        if (last_ready[2] !== 1'b1 || last_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL orphan_concurrent got ready2=%b ready0=%b, required 1/0", last_ready[2], last_ready[0]);
        end
        drain(50);
        checks++;
        if (out_log.size() != 2 || out_log[0].ch != 0) begin
            errors++;
            $display("FAIL orphan_concurrent_pkt got %0d beats, required 2 on ch 0", out_log.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        int n;
        do_reset();
        push_pkt(2, 6);
        n = 0;
        while (out_log.size() < 2 && n < 20) begin
            run_cycle();
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        checks++;
        if (bus0.o_avst_valid !== 1'b0 || bus1.o_avst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear got %b/%b, required 0", bus0.o_avst_valid, bus1.o_avst_valid);
        end
        do_reset();
        push_pkt(2, 3);
        drain(50);
        checks++;
        if (out_log.size() != 3 || !out_log[0].sop) begin
            errors++;
            $display("FAIL rst_mid_recover got %0d beats, required 3 starting with SOP", out_log.size());
        end
    endtask

    task automatic test_random();
        int total;
        do_reset();
        gap_pct  = 20;
        rdy_mode = 1;
        total    = 0;
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < NP; p++) begin
                int len;
                len = int'($urandom_range(1, 6));
                push_pkt(p, len);
                total += len;
            end
        end
        drain(3000);
        checks++;
        if (out_log.size() != total) begin
            errors++;
            $display("FAIL rand_total got %0d beats, required %0d", out_log.size(), total);
        end
    endtask

`ifdef PKT_MUX_STATS_EN
    task automatic test_stats();
        do_reset();
        push_orphan(0);
        for (int k = 1; k <= 3; k++) begin
            push_pkt(0, 2);
            drain(50);
            @(negedge clk);
            checks++;
            if (cnt0[0] !== 32'(k) || cnt1[0] !== 32'(k)) begin
                errors++;
                $display("FAIL stats_count got %0d/%0d, required %0d", cnt0[0], cnt1[0], k);
            end
            checks++;
            if (cnt0[1] !== 0 || cnt0[2] !== 0 || cnt0[3] !== 0) begin
                errors++;
                $display("FAIL stats_others got %0d,%0d,%0d, required 0", cnt0[1], cnt0[2], cnt0[3]);
            end
        end
        do_reset();
        #1;
        checks++;
        if (cnt0 !== '0 || cnt1 !== '0) begin
            errors++;
            $display("FAIL stats_reset got %h, required 0", cnt0);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rdy_mode   = 0;
        gap_pct    = 0;
        pat_idx    = 0;
        prev_stall = 0;
        in_pkt     = 0;
        cur_ch     = 0;
        test_reset();
        test_round_robin();
        test_fairness();
        test_backpressure();
        test_onehot();
        test_orphan();
        test_reset_mid_packet();
        test_random();
`ifdef PKT_MUX_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
